// File: rtl/uart_tx_sched.sv
// Byte FIFO in front of a UART transmitter: bus stores enqueue bytes, and a
// four-state scheduler hands them one at a time to uart_tx (load, start, wait for done).
module uart_tx_sched #(
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cs,
  input  logic          we,
  input  logic [DW-1:0] data_i,
  input  logic          flush_i,
  input  logic          clr_ovf_i,
  input  logic          done_uart,
  output logic [DW-1:0] tx_data_o,
  output logic          byte_ready,
  output logic          t_byte,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o,
  output logic          busy_o,
  output logic          ovf_o,
  output logic [1:0]    state_o
);

  localparam int AW = $clog2(DEPTH);

  // Handshake: a push is offered when cs && we; it is taken at the edge only
  // if full_o is low (and no flush). uart_tx sees byte_ready (load) then t_byte
  // (start), and answers with a one-cycle done_uart, honoured only in S_WAIT.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_START = 2'd2,
    S_WAIT  = 2'd3
  } state_e;

  state_e        state_q;
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [DW-1:0] tx_data_q;
  logic          byte_ready_q;
  logic          t_byte_q;
  logic          push_req;
  logic          push_en;
  logic          pop_en;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign busy_o     = (state_q != S_IDLE);
  assign ovf_o      = ovf_q;
  assign tx_data_o  = tx_data_q;
  assign byte_ready = byte_ready_q;
  assign t_byte     = t_byte_q;
  assign state_o    = state_q;

  always_comb begin
    push_req = cs && we;
    push_en  = push_req && !full_o && !flush_i;
    pop_en   = (state_q == S_IDLE) && !empty_o && !flush_i;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    // A dropped push outranks a clear on the same edge.
    ovf_d = ovf_q;
    if (clr_ovf_i) ovf_d = 1'b0;
    if (push_req && full_o) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Flush never touches the scheduler: a frame already past S_IDLE runs to completion.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      tx_data_q    <= '0;
      byte_ready_q <= 1'b0;
      t_byte_q     <= 1'b0;
    end else begin
      byte_ready_q <= 1'b0;
      t_byte_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop_en) begin
            state_q      <= S_LOAD;
            tx_data_q    <= mem_q[rd_ptr_q];
            byte_ready_q <= 1'b1;
          end
        end
        S_LOAD: begin
          state_q  <= S_START;
          t_byte_q <= 1'b1;
        end
        S_START: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (done_uart) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: bytes expected on the uart_tx side are
// queued at push time and matched by a monitor on every byte_ready strobe.
module tb_uart_tx_sched;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk_i     = 1'b0;
  logic          rst_i     = 1'b0;
  logic          cs        = 1'b0;
  logic          we        = 1'b0;
  logic [DW-1:0] data_i    = '0;
  logic          flush_i   = 1'b0;
  logic          clr_ovf_i = 1'b0;
  logic          done_uart = 1'b0;
  logic [DW-1:0] tx_data_o;
  logic          byte_ready;
  logic          t_byte;
  logic          full_o;
  logic          empty_o;
  logic [CW-1:0] count_o;
  logic          busy_o;
  logic          ovf_o;
  logic [1:0]    state_o;

  int            checks = 0;
  int            errors = 0;
  int            br_cnt = 0;
  logic          prev_br = 1'b0;
  logic [DW-1:0] exp_q[$];

  uart_tx_sched #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cs(cs), .we(we), .data_i(data_i),
    .flush_i(flush_i), .clr_ovf_i(clr_ovf_i), .done_uart(done_uart),
    .tx_data_o(tx_data_o), .byte_ready(byte_ready), .t_byte(t_byte),
    .full_o(full_o), .empty_o(empty_o), .count_o(count_o), .busy_o(busy_o),
    .ovf_o(ovf_o), .state_o(state_o)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        if (byte_ready) begin
          br_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte_ready actual=0x%0h required=none", tx_data_o);
          end else begin
            chk("tx_data", 32'(tx_data_o), 32'(exp_q.pop_front()));
          end
        end
        if (t_byte) chk("t_byte_after_load", 32'(prev_br), 32'd1);
        prev_br = byte_ready;
      end else begin
        prev_br = 1'b0;
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d, input bit accept);
    cs = 1'b1;
    we = 1'b1;
    data_i = d;
    if (accept) exp_q.push_back(d);
    step();
    cs = 1'b0;
    we = 1'b0;
  endtask

  task automatic pulse_done();
    done_uart = 1'b1;
    step();
    done_uart = 1'b0;
  endtask

  task automatic single_frame(input logic [DW-1:0] d);
    push(d, 1'b1);
    chk("sf_count_e0", 32'(count_o), 32'd1);
    chk("sf_br_e0", 32'(byte_ready), 32'd0);
    chk("sf_busy_e0", 32'(busy_o), 32'd0);
    step();
    chk("sf_br_e1", 32'(byte_ready), 32'd1);
    chk("sf_txd_e1", 32'(tx_data_o), 32'(d));
    chk("sf_busy_e1", 32'(busy_o), 32'd1);
    chk("sf_count_e1", 32'(count_o), 32'd0);
    chk("sf_tb_e1", 32'(t_byte), 32'd0);
    step();
    chk("sf_tb_e2", 32'(t_byte), 32'd1);
    chk("sf_br_e2", 32'(byte_ready), 32'd0);
    step();
    chk("sf_tb_e3", 32'(t_byte), 32'd0);
    chk("sf_state_wait", 32'(state_o), 32'd3);
    pulse_done();
    chk("sf_busy_done", 32'(busy_o), 32'd0);
    chk("sf_empty_done", 32'(empty_o), 32'd1);
  endtask

  initial begin
    int base;
    int idx;
    int timer;
    int cyc;

    // Reset values while rst_i is low
    #12;
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_full", 32'(full_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_ovf", 32'(ovf_o), 32'd0);
    chk("rst_txd", 32'(tx_data_o), 32'd0);
    chk("rst_strobes", 32'({byte_ready, t_byte}), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    step();

    // Single byte
    single_frame(8'h41);

    // Fill and overflow
    for (int i = 0; i < 9; i++) push(8'(i), 1'b1);
    chk("fill_full", 32'(full_o), 32'd1);
    chk("fill_count", 32'(count_o), 32'd8);
    chk("fill_ovf", 32'(ovf_o), 32'd0);
    chk("fill_state", 32'(state_o), 32'd3);
    push(8'h09, 1'b0);
    chk("ovf_set", 32'(ovf_o), 32'd1);
    chk("ovf_count", 32'(count_o), 32'd8);
    clr_ovf_i = 1'b1;
    step();
    clr_ovf_i = 1'b0;
    chk("ovf_clr", 32'(ovf_o), 32'd0);
    clr_ovf_i = 1'b1;
    push(8'hAA, 1'b0);
    clr_ovf_i = 1'b0;
    chk("ovf_set_wins", 32'(ovf_o), 32'd1);
    clr_ovf_i = 1'b1;
    step();
    clr_ovf_i = 1'b0;
    chk("ovf_clr2", 32'(ovf_o), 32'd0);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    exp_q.delete();
    chk("fill_flush_count", 32'(count_o), 32'd0);
    chk("fill_flush_full", 32'(full_o), 32'd0);
    chk("fill_flush_busy", 32'(busy_o), 32'd1);
    pulse_done();
    repeat (4) step();
    chk("fill_idle", 32'(busy_o), 32'd0);

    // Wrap-around stream of 20 bytes
    base = br_cnt;
    idx = 0;
    timer = 0;
    cyc = 0;
    while (cyc < 2000 && !(idx == 20 && br_cnt - base == 20 && busy_o == 1'b0 && exp_q.size() == 0)) begin
      done_uart = (timer == 1);
      if (t_byte) timer = 5;
      else if (timer > 0) timer--;
      if (idx < 20 && !full_o) begin
        cs = 1'b1;
        we = 1'b1;
        data_i = 8'(8'h10 + idx);
        exp_q.push_back(data_i);
        idx++;
      end else begin
        cs = 1'b0;
        we = 1'b0;
      end
      step();
      cyc++;
    end
    cs = 1'b0;
    we = 1'b0;
    done_uart = 1'b0;
    chk("wrap_in_time", 32'(cyc < 2000), 32'd1);
    chk("wrap_frames", 32'(br_cnt - base), 32'd20);

    // Flush mid-frame
    push(8'hA0, 1'b1);
    push(8'hA1, 1'b1);
    push(8'hA2, 1'b1);
    step();
    chk("fl_state_wait", 32'(state_o), 32'd3);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    exp_q.delete();
    chk("fl_count", 32'(count_o), 32'd0);
    chk("fl_empty", 32'(empty_o), 32'd1);
    chk("fl_busy", 32'(busy_o), 32'd1);
    base = br_cnt;
    repeat (3) step();
    chk("fl_still_wait", 32'(state_o), 32'd3);
    pulse_done();
    repeat (6) step();
    chk("fl_no_more_br", 32'(br_cnt - base), 32'd0);
    chk("fl_idle", 32'(busy_o), 32'd0);
    chk("fl_txd_kept", 32'(tx_data_o), 32'hA0);

    // Asynchronous reset in START
    push(8'h66, 1'b1);
    push(8'h67, 1'b1);
    step();
    chk("ar_tb_start", 32'(t_byte), 32'd1);
    chk("ar_count_pre", 32'(count_o), 32'd1);
    #2;
    rst_i = 1'b0;
    #1;
    chk("ar_tb", 32'(t_byte), 32'd0);
    chk("ar_busy", 32'(busy_o), 32'd0);
    chk("ar_count", 32'(count_o), 32'd0);
    chk("ar_txd", 32'(tx_data_o), 32'd0);
    exp_q.delete();
    @(negedge clk_i);
    rst_i = 1'b1;
    step();
    base = br_cnt;
    repeat (4) step();
    chk("ar_no_strobe", 32'(br_cnt - base), 32'd0);
    single_frame(8'h55);

    // Spurious done in IDLE and LOAD
    pulse_done();
    chk("sp_idle_state", 32'(state_o), 32'd0);
    push(8'h77, 1'b1);
    step();
    chk("sp_load_state", 32'(state_o), 32'd1);
    done_uart = 1'b1;
    step();
    done_uart = 1'b0;
    chk("sp_start_state", 32'(state_o), 32'd2);
    step();
    repeat (5) step();
    chk("sp_wait_hold", 32'(state_o), 32'd3);
    pulse_done();
    chk("sp_done_idle", 32'(state_o), 32'd0);

    repeat (3) step();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
Parameters:
REQ-001 DW, 8, width of one UART data byte.
REQ-002 DEPTH, 8, FIFO entries; power of two, at least 2.
REQ-003 CW, $clog2(DEPTH)+1, width of count_o.

Ports:
REQ-004 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_i  input  1  reset, asynchronous and active-low.
REQ-006 cs  input  1  chip select from the peripheral bus (UART address decoded).
REQ-007 we  input  1  store strobe; a push is requested when cs&&we.
REQ-008 data_i  input  DW  byte to enqueue; equals store data bits [7:0].
REQ-009 flush_i  input  1  synchronous FIFO clear.
REQ-010 clr_ovf_i  input  1  clears the sticky overflow flag.
REQ-011 done_uart  input  1  one-cycle pulse from uart_tx: frame finished.
REQ-012 tx_data_o  output  DW  byte presented to uart_tx data_i.
REQ-013 byte_ready  output  1  load strobe to uart_tx.
REQ-014 t_byte  output  1  start-transmit strobe to uart_tx.
REQ-015 full_o  output  1  count_o==DEPTH.
REQ-016 empty_o  output  1  count_o==0.
REQ-017 count_o  output  CW  number of FIFO entries held.
REQ-018 busy_o  output  1  FSM is not in IDLE.
REQ-019 ovf_o  output  1  sticky flag: a push was dropped.

Function
REQ-020 The FIFO is circular, with rd_ptr/wr_ptr of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0, and a separate counter.
REQ-021 Push: when cs&&we&&!full_o at an edge, write data_i at wr_ptr, increment wr_ptr and add 1 to count.
REQ-022 Push while full_o: data is dropped, pointers and count are unchanged, and ovf_o is set at that edge.
REQ-023 ovf_o stays 1 until clr_ovf_i is sampled high; if set and clear occur on the same edge, set wins.
REQ-024 The FSM has four states: IDLE, LOAD, START, WAIT.
REQ-025 IDLE->LOAD when !empty_o.
- At that edge: tx_data_o <= FIFO[rd_ptr], rd_ptr increments (pop), count decrements.
REQ-026 LOAD->START unconditionally; byte_ready=1 for exactly the LOAD cycle.
REQ-027 START->WAIT unconditionally; t_byte=1 for exactly the START cycle.
REQ-028 WAIT->IDLE on done_uart=1; otherwise WAIT holds indefinitely.
REQ-029 done_uart is ignored in IDLE, LOAD and START.
REQ-030 Latency: a push accepted at edge E0 into an empty, idle block gives:
- byte_ready high in cycle E1-E2;
- t_byte high in cycle E2-E3.
REQ-031 Back-to-back frames: after done_uart at edge En, the next byte_ready is high in cycle En+1-En+2 if the FIFO is non-empty.
REQ-032 tx_data_o holds its value from the pop edge until the next pop.
REQ-033 A push and a pop on the same edge leave count unchanged; both pointers advance.
REQ-034 A push is accepted only when count<DEPTH before the edge, even if a pop occurs on that edge.
REQ-035 flush_i at an edge sets rd_ptr=wr_ptr=0 and count=0.
- Flush has priority over a push and a pop on the same edge; neither takes effect.
- The FSM is not affected: a frame already in LOAD, START or WAIT completes.
- tx_data_o is unchanged.
REQ-036 count_o, full_o, empty_o and busy_o are derived from registered state only, with no combinational path from inputs.

Reset
REQ-037 While rst_i=0, independent of clk_i:
- state=IDLE;
- rd_ptr=wr_ptr=0, count_o=0, empty_o=1, full_o=0;
- tx_data_o=0, byte_ready=0, t_byte=0, busy_o=0, ovf_o=0.
REQ-038 FIFO storage contents are not reset.
REQ-039 Reset asserted mid-frame abandons the frame immediately; no strobe is issued after reset release until a new push occurs.
REQ-040 Reset deassertion is synchronized externally; the first active edge after release may accept a push.

Verification
REQ-041 Single byte: push 0x41 at E0 -> byte_ready in cycle E1, tx_data_o=0x41, t_byte in cycle E2, busy_o=1; done_uart pulse -> busy_o=0, empty_o=1.
REQ-042 Fill and overflow (DEPTH=8): 9 pushes 0x00..0x08 with done_uart never pulsed -> byte 0x00 is popped, 8 bytes remain, full_o=1, 0x01..0x08 are retained with no drop, ovf_o=0; a 10th push 0x09 -> dropped, ovf_o=1; clr_ovf_i -> ovf_o=0.
REQ-043 Wrap-around: 20 bytes 0x10..0x23 streamed, done_uart pulsed 5 cycles after each t_byte -> tx_data_o sequence is exactly 0x10..0x23 in order, with no loss or duplication.
REQ-044 Flush mid-frame: 3 bytes queued, flush_i in WAIT -> count_o=0 the next cycle; the current frame completes on done_uart; no further byte_ready.
REQ-045 Async reset in START: rst_i=0 between edges -> t_byte, busy_o and count_o go to 0 before the next edge; after release, a push 0x55 gives the normal REQ-030 timing.
REQ-046 Spurious done: done_uart pulsed in IDLE and in LOAD -> no state change beyond the normal transitions; the frame still waits for a done_uart in WAIT.
